// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite master engine: response codes, FSM states,
// and the latched command/response control records.
package axi4_lite_pkg;

    localparam logic [1:0] OKAY   = 2'd0;
    localparam logic [1:0] EXOKAY = 2'd1;
    localparam logic [1:0] SLVERR = 2'd2;
    localparam logic [1:0] DECERR = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } eng_state_e;

    typedef struct packed {
        logic       write;
        logic [2:0] prot;
    } cmd_ctl_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] resp;
    } rsp_ctl_t;

endpackage

// File: rtl/axi4_lite_delay_cnt.sv
// Loadable saturating down-counter; expire_o is high when the count for the
// next cycle is zero, so a registered VALID/READY set from it rises on time.
module axi4_lite_delay_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    assign expire_o = (cnt_d == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axi4_lite_master_engine.sv
// AXI4-Lite master: runs one write (AW/W/B) or read (AR/R) transaction per
// accepted command, with programmable per-channel delays.
module axi4_lite_master_engine
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DELAY_W = 4
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [2:0]          cmd_prot,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    input  logic [DELAY_W-1:0]  cmd_aw_delay,
    input  logic [DELAY_W-1:0]  cmd_w_delay,
    input  logic [DELAY_W-1:0]  cmd_b_delay,
    output logic                rsp_valid,
    output logic [1:0]          rsp_resp,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [DATA_W+1:0]   rsp_r,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic [2:0]          AWPROT,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY,
    output logic [ADDR_W-1:0]   ARADDR,
    output logic [2:0]          ARPROT,
    output logic                ARVALID,
    input  logic                ARREADY,
    input  logic [DATA_W-1:0]   RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RVALID,
    output logic                RREADY
);

    eng_state_e          st_q;
    cmd_ctl_t            ctl_q;
    rsp_ctl_t            rsp_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic [DELAY_W-1:0]  b_delay_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                cmd_ready_q;
    logic                awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
    logic                aw_done_q, w_done_q;

    logic accept, aw_hs, w_hs, ar_hs, b_hs, r_hs, wr_last, rsp_load;
    logic a_exp, w_exp, b_exp;

    assign accept  = cmd_valid && cmd_ready_q && (st_q == IDLE);
    assign aw_hs   = awvalid_q && AWREADY;
    assign w_hs    = wvalid_q && WREADY;
    assign ar_hs   = arvalid_q && ARREADY;
    assign b_hs    = bready_q && BVALID;
    assign r_hs    = rready_q && RVALID;
    assign wr_last = (st_q == WR_ADDR_DATA) && (aw_done_q || aw_hs) && (w_done_q || w_hs);
    // The response-wait counter is reloaded at the last address/data handshake.
    assign rsp_load = wr_last || ((st_q == RD_ADDR) && ar_hs);

    axi4_lite_delay_cnt #(.W(DELAY_W)) u_addr_cnt (
        .clk_i      (ACLK),
        .rst_i      (ARESET),
        .load_i     (accept),
        .load_val_i (cmd_aw_delay),
        .expire_o   (a_exp)
    );

    axi4_lite_delay_cnt #(.W(DELAY_W)) u_data_cnt (
        .clk_i      (ACLK),
        .rst_i      (ARESET),
        .load_i     (accept),
        .load_val_i (cmd_w_delay),
        .expire_o   (w_exp)
    );

    axi4_lite_delay_cnt #(.W(DELAY_W)) u_resp_cnt (
        .clk_i      (ACLK),
        .rst_i      (ARESET),
        .load_i     (rsp_load),
        .load_val_i (b_delay_q),
        .expire_o   (b_exp)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            st_q        <= IDLE;
            ctl_q       <= '0;
            rsp_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            b_delay_q   <= '0;
            rdata_q     <= '0;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
        end else begin
            case (st_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    rsp_q.valid <= 1'b0;
                    if (accept) begin
                        cmd_ready_q <= 1'b0;
                        ctl_q.write <= cmd_write;
                        ctl_q.prot  <= cmd_prot;
                        addr_q      <= cmd_addr;
                        wdata_q     <= cmd_wdata;
                        wstrb_q     <= cmd_wstrb;
                        b_delay_q   <= cmd_b_delay;
                        aw_done_q   <= 1'b0;
                        w_done_q    <= 1'b0;
                        if (cmd_write) begin
                            st_q      <= WR_ADDR_DATA;
                            awvalid_q <= a_exp;
                            wvalid_q  <= w_exp;
                        end else begin
                            st_q      <= RD_ADDR;
                            arvalid_q <= a_exp;
                        end
                    end
                end
                WR_ADDR_DATA: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end else if (!aw_done_q && a_exp) begin
                        awvalid_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end else if (!w_done_q && w_exp) begin
                        wvalid_q <= 1'b1;
                    end
                    if (wr_last) begin
                        st_q     <= WR_RESP;
                        bready_q <= b_exp;
                    end
                end
                WR_RESP: begin
                    if (b_hs) begin
                        bready_q    <= 1'b0;
                        rsp_q.resp  <= BRESP;
                        rsp_q.valid <= 1'b1;
                        rdata_q     <= '0;
                        st_q        <= DONE;
                    end else if (b_exp) begin
                        bready_q <= 1'b1;
                    end
                end
                RD_ADDR: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= b_exp;
                        st_q      <= RD_DATA;
                    end else if (a_exp) begin
                        arvalid_q <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (r_hs) begin
                        rready_q    <= 1'b0;
                        rsp_q.resp  <= RRESP;
                        rsp_q.valid <= 1'b1;
                        rdata_q     <= RDATA;
                        st_q        <= DONE;
                    end else if (b_exp) begin
                        rready_q <= 1'b1;
                    end
                end
                DONE: begin
                    rsp_q.valid <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    st_q        <= IDLE;
                end
                default: st_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_q.valid;
    assign rsp_resp  = rsp_q.resp;
    assign rsp_rdata = rdata_q;
    assign rsp_r     = {rdata_q, rsp_q.resp};
    assign AWADDR    = addr_q;
    assign AWPROT    = ctl_q.prot;
    assign AWVALID   = awvalid_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;
    assign WVALID    = wvalid_q;
    assign BREADY    = bready_q;
    assign ARADDR    = addr_q;
    assign ARPROT    = ctl_q.prot;
    assign ARVALID   = arvalid_q;
    assign RREADY    = rready_q;

endmodule

// File: tb/tb_axi4_lite_master_engine.sv
// Scoreboarded bench for axi4_lite_master_engine with a small AXI4-Lite slave
// model and directed command vectors.
module tb_axi4_lite_master_engine;

    logic        ACLK, ARESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [2:0]  cmd_prot;
    logic [3:0]  cmd_wstrb, cmd_aw_delay, cmd_w_delay, cmd_b_delay;
    logic        rsp_valid;
    logic [1:0]  rsp_resp;
    logic [31:0] rsp_rdata;
    logic [33:0] rsp_r;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [2:0]  AWPROT, ARPROT;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]  BRESP, RRESP;

    axi4_lite_master_engine #(.ADDR_W(32), .DATA_W(32), .DELAY_W(4)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_prot(cmd_prot), .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb), .cmd_aw_delay(cmd_aw_delay),
        .cmd_w_delay(cmd_w_delay), .cmd_b_delay(cmd_b_delay),
        .rsp_valid(rsp_valid), .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata), .rsp_r(rsp_r),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Slave model: B is raised once both AW and W have been seen, R one cycle
    // after AR; both are held until the master's READY.
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;
    logic        aw_seen, w_seen, aw_n, w_n;
    assign aw_n = aw_seen | (AWVALID & AWREADY);
    assign w_n  = w_seen  | (WVALID & WREADY);

    always @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_seen <= 1'b0; w_seen <= 1'b0;
            BVALID <= 1'b0; BRESP <= 2'd0;
            RVALID <= 1'b0; RDATA <= 32'd0; RRESP <= 2'd0;
        end else begin
            if (BVALID && BREADY) begin
                BVALID <= 1'b0;
                aw_seen <= 1'b0; w_seen <= 1'b0;
            end else if (aw_n && w_n && !BVALID) begin
                BVALID <= 1'b1; BRESP <= s_bresp;
                aw_seen <= 1'b0; w_seen <= 1'b0;
            end else begin
                aw_seen <= aw_n; w_seen <= w_n;
            end
            if (RVALID && RREADY) begin
                RVALID <= 1'b0;
            end else if (ARVALID && ARREADY) begin
                RVALID <= 1'b1; RDATA <= s_rdata; RRESP <= s_rresp;
            end
        end
    end

    typedef struct {
        logic [33:0] r;
        int          cyc;
    } exp_t;
    exp_t sbq[$];

    always @(negedge ACLK) begin
        if (!ARESET && rsp_valid) begin
            if (sbq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_rsp actual=%0h required=none", rsp_r);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("rsp_r", 64'(rsp_r), 64'(e.r));
                check("rsp_resp", 64'(rsp_resp), 64'(e.r[1:0]));
                check("rsp_rdata", 64'(rsp_rdata), 64'(e.r[33:2]));
                if (e.cyc >= 0) check("rsp_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic drive_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [3:0] ad,
                             input logic [3:0] wd, input logic [3:0] bd);
        cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        cmd_prot = 3'b010; cmd_aw_delay = ad; cmd_w_delay = wd; cmd_b_delay = bd;
    endtask

    // Returns after the accepting edge; t is the acceptance cycle T.
    task automatic send(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [3:0] ad, input logic [3:0] wd,
                        input logic [3:0] bd, input bit push, input logic [33:0] exp_r,
                        input int lat, output int t);
        int n = 0;
        exp_t e;
        @(negedge ACLK);
        while (!cmd_ready && n < 200) begin
            @(negedge ACLK);
            n++;
        end
        if (n >= 200) check("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
        drive_cmd(wr, addr, data, strb, ad, wd, bd);
        cmd_valid = 1'b1;
        t = cyc;
        if (push) begin
            e.r = exp_r;
            e.cyc = (lat >= 0) ? t + lat : -1;
            sbq.push_back(e);
        end
        @(posedge ACLK);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge ACLK);
            n++;
        end
        if (n >= 200) check("drain_timeout", 64'(sbq.size()), 64'd0);
    endtask

    int t, t2, n;

    initial begin
        ARESET = 1'b1; cmd_valid = 1'b0;
        drive_cmd(1'b0, 32'd0, 32'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        AWREADY = 1'b1; WREADY = 1'b1; ARREADY = 1'b1;
        s_bresp = 2'd0; s_rresp = 2'd0; s_rdata = 32'd0;

        repeat (2) @(negedge ACLK);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_valids", 64'({AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid}), 64'd0);
        check("rst_rsp_r", 64'(rsp_r), 64'd0);
        ARESET = 1'b0;
        @(negedge ACLK);
        check("rst_release_ready", 64'(cmd_ready), 64'd1);

        // Read 0x00, zero delays
        s_rdata = 32'h12345678; s_rresp = 2'd0;
        send(1'b0, 32'h0, 32'h0, 4'h0, 4'd0, 4'd0, 4'd0, 1'b1, 34'h048D159E0, 3, t);
        @(negedge ACLK);
        check("rd_arvalid_t1", 64'(ARVALID), 64'd1);
        check("rd_araddr", 64'(ARADDR), 64'd0);
        check("rd_arprot", 64'(ARPROT), 64'd2);
        check("rd_cmd_ready_busy", 64'(cmd_ready), 64'd0);
        drain();

        // Write 0x08 with aw_delay 1
        send(1'b1, 32'h8, 32'h000A0010, 4'hF, 4'd1, 4'd0, 4'd0, 1'b1, 34'h0, 4, t);
        @(negedge ACLK);
        check("wr_wvalid_t1", 64'(WVALID), 64'd1);
        check("wr_awvalid_t1", 64'(AWVALID), 64'd0);
        check("wr_wdata", 64'(WDATA), 64'h000A0010);
        check("wr_wstrb", 64'(WSTRB), 64'hF);
        @(negedge ACLK);
        check("wr_awvalid_t2", 64'(AWVALID), 64'd1);
        check("wr_awaddr", 64'(AWADDR), 64'h8);
        check("wr_wvalid_t2", 64'(WVALID), 64'd0);
        drain();

        // AWREADY low for five cycles, b_delay 2
        AWREADY = 1'b0;
        send(1'b1, 32'h4, 32'h55, 4'h3, 4'd0, 4'd0, 4'd2, 1'b1, 34'h0, 10, t);
        for (int k = 1; k <= 5; k++) begin
            @(negedge ACLK);
            check("stall_awvalid", 64'(AWVALID), 64'd1);
            check("stall_awaddr", 64'(AWADDR), 64'h4);
            check("stall_bready", 64'(BREADY), 64'd0);
            if (k == 2) check("stall_w_done", 64'(WVALID), 64'd0);
        end
        @(negedge ACLK);
        AWREADY = 1'b1;
        @(negedge ACLK);
        check("stall_bready_h1", 64'(BREADY), 64'd0);
        @(negedge ACLK);
        check("stall_bready_h2", 64'(BREADY), 64'd0);
        @(negedge ACLK);
        check("stall_bready_h3", 64'(BREADY), 64'd1);
        drain();

        // SLVERR on write to 0x0C
        s_bresp = 2'd2;
        send(1'b1, 32'hC, 32'h77, 4'hF, 4'd0, 4'd0, 4'd0, 1'b1, 34'h2, 3, t);
        drain();
        s_bresp = 2'd0;

        // Reset while WVALID is pending
        WREADY = 1'b0;
        send(1'b1, 32'h20, 32'hDEAD, 4'hF, 4'd0, 4'd0, 4'd0, 1'b0, 34'h0, -1, t);
        @(negedge ACLK);
        check("abort_wvalid_t1", 64'(WVALID), 64'd1);
        @(negedge ACLK);
        check("abort_wvalid_t2", 64'(WVALID), 64'd1);
        ARESET = 1'b1;
        #1;
        check("abort_valids", 64'({AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid}), 64'd0);
        check("abort_payload", 64'({AWADDR, WDATA}), 64'd0);
        check("abort_rsp_r", 64'(rsp_r), 64'd0);
        check("abort_cmd_ready", 64'(cmd_ready), 64'd0);
        @(negedge ACLK);
        ARESET = 1'b0; WREADY = 1'b1;
        @(negedge ACLK);
        check("abort_ready_after", 64'(cmd_ready), 64'd1);
        repeat (4) @(negedge ACLK);

        // Back-to-back write then read with cmd_valid held high
        s_rdata = 32'hCAFEF00D; s_rresp = 2'd1;
        @(negedge ACLK);
        drive_cmd(1'b1, 32'h10, 32'h10000000, 4'hF, 4'd0, 4'd0, 4'd0);
        cmd_valid = 1'b1;
        t = cyc;
        sbq.push_back('{r: 34'h0, cyc: t + 3});
        sbq.push_back('{r: {32'hCAFEF00D, 2'b01}, cyc: t + 7});
        @(posedge ACLK);
        #1 drive_cmd(1'b0, 32'h0, 32'h0, 4'h0, 4'd0, 4'd0, 4'd0);
        n = 0;
        @(negedge ACLK);
        while (!cmd_ready && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        t2 = cyc;
        check("b2b_second_accept", 64'(t2), 64'(t + 4));
        @(posedge ACLK);
        #1 cmd_valid = 1'b0;
        drain();
        repeat (3) @(negedge ACLK);
        check("final_queue_empty", 64'(sbq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
